// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on operand and result sides.
// Logic ops, ADD, SUB and SLT finish in one cycle; MUL and the shifts iterate one step per cycle.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [SHW-1:0]   shamt;
    logic             is_shift;

    logic [WIDTH-1:0] opa_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] fin;

    assign in_ready = (state == IDLE);
    assign shamt    = b[SHW-1:0];
    assign is_shift = (aluop == OP_SLL) || (aluop == OP_SRL);

    // Single-cycle result and flags, computed straight from the input operands.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (aluop)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = a;
        endcase
    end

    // One iteration step: opa_q is the left-shifting multiplicand or the shift register.
    always_comb begin
        acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);
        if (op_q == OP_SRL)
            opa_nxt = {1'b0, opa_q[WIDTH-1:1]};
        else
            opa_nxt = {opa_q[WIDTH-2:0], 1'b0};
        fin = (op_q == OP_MUL) ? acc_nxt : opa_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= aluop;
                        opa_q <= a;
                        opb_q <= b;
                        if (aluop == OP_MUL) begin
                            acc_q <= '0;
                            cnt_q <= CW'(WIDTH);
                            state <= EXEC;
                        end else if (is_shift && (shamt != '0)) begin
                            cnt_q <= CW'(shamt);
                            state <= EXEC;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_c;
                            overflow  <= alu_v;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                EXEC: begin
                    acc_q <= acc_nxt;
                    opa_q <= opa_nxt;
                    opb_q <= {1'b0, opb_q[WIDTH-1:1]};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result    <= fin;
                        zero      <= (fin == '0);
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
